// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: checks in-flight branch predictions against MEM-stage
// outcomes, drives predictor update strobes, flush and fetch redirect.
module branch_resolution_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [31:0]      pred_pc,
    input  logic [31:0]      pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             branch_mem_sig,
    output logic             actual_branch_decision,
    output logic [31:0]      update_branch_addr,
    output logic             mispredict,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             err_underflow,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] q_taken;
    logic [31:0]      q_pc  [DEPTH];
    logic [31:0]      q_tgt [DEPTH];
    logic [FW-1:0]    rcv_cnt;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        under;
    logic        mis;
    logic        h_taken;
    logic [31:0] h_pc;
    logic [31:0] h_tgt;

    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign pred_ready = (state == RUN) && !full;
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && (state == RUN) && !empty;
    assign under      = res_valid && (state == RUN) && empty;

    assign h_taken = q_taken[rd_ptr[AW-1:0]];
    assign h_pc    = q_pc[rd_ptr[AW-1:0]];
    assign h_tgt   = q_tgt[rd_ptr[AW-1:0]];

    // Wrong direction, or right direction but taken to the wrong place
    assign mis = pop && ((h_taken != res_taken)
              || (res_taken && h_taken && (h_tgt != res_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (mis) begin
                    state_nx = RECOVER;
                end
            end
            RECOVER: begin
                if (rcv_cnt == '0) begin
                    state_nx = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_taken <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]  <= '0;
                q_tgt[i] <= '0;
            end
        end else if (push) begin
            q_taken[wr_ptr[AW-1:0]] <= pred_taken;
            q_pc[wr_ptr[AW-1:0]]    <= pred_pc;
            q_tgt[wr_ptr[AW-1:0]]   <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            rcv_cnt                <= '0;
            branch_mem_sig         <= 1'b0;
            actual_branch_decision <= 1'b0;
            update_branch_addr     <= '0;
            mispredict             <= 1'b0;
            flush                  <= 1'b0;
            redirect_pc            <= '0;
            err_underflow          <= 1'b0;
            branch_count           <= '0;
            mispredict_count       <= '0;
        end else begin
            branch_mem_sig <= 1'b0;
            flush          <= 1'b0;

            // A mispredict discards every record, including one arriving now
            if (mis) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
            end

            if (pop) begin
                branch_mem_sig         <= 1'b1;
                actual_branch_decision <= res_taken;
                update_branch_addr     <= h_pc;
                mispredict             <= mis;
                if (branch_count != '1) begin
                    branch_count <= branch_count + CNT_W'(1);
                end
            end

            if (mis) begin
                flush       <= 1'b1;
                redirect_pc <= res_taken ? res_target : h_pc + 32'd4;
                if (mispredict_count != '1) begin
                    mispredict_count <= mispredict_count + CNT_W'(1);
                end
            end

            if (under) begin
                err_underflow <= 1'b1;
            end

            if (mis) begin
                rcv_cnt <= FW'(FLUSH_CYCLES - 1);
            end else if ((state == RECOVER) && (rcv_cnt != '0)) begin
                rcv_cnt <= rcv_cnt - FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_branch_resolution_unit;

    localparam int DEPTH = 4;
    localparam int FLUSH = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    typedef struct {
        logic        t;
        logic [31:0] pc;
        logic [31:0] tgt;
    } rec_t;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b1;
    logic          pred_valid  = 1'b0;
    logic          pred_taken  = 1'b0;
    logic [31:0]   pred_pc     = '0;
    logic [31:0]   pred_target = '0;
    logic          res_valid   = 1'b0;
    logic          res_taken   = 1'b0;
    logic [31:0]   res_target  = '0;
    logic          pred_ready;
    logic          branch_mem_sig;
    logic          actual_branch_decision;
    logic [31:0]   update_branch_addr;
    logic          mispredict;
    logic          flush;
    logic [31:0]   redirect_pc;
    logic          err_underflow;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    branch_resolution_unit #(
        .DEPTH(DEPTH),
        .FLUSH_CYCLES(FLUSH),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_pc(pred_pc),
        .pred_target(pred_target),
        .pred_ready(pred_ready),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .res_target(res_target),
        .branch_mem_sig(branch_mem_sig),
        .actual_branch_decision(actual_branch_decision),
        .update_branch_addr(update_branch_addr),
        .mispredict(mispredict),
        .flush(flush),
        .redirect_pc(redirect_pc),
        .err_underflow(err_underflow),
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    rec_t        mq[$];
    int          m_left = 0;
    bit          m_bms  = 0;
    bit          m_abd  = 0;
    bit          m_mis  = 0;
    bit          m_fl   = 0;
    bit          m_err  = 0;
    logic [31:0] m_uba  = '0;
    logic [31:0] m_rpc  = '0;
    int          m_bc   = 0;
    int          m_mc   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_left = 0;
        m_bms  = 0;
        m_abd  = 0;
        m_mis  = 0;
        m_fl   = 0;
        m_err  = 0;
        m_uba  = '0;
        m_rpc  = '0;
        m_bc   = 0;
        m_mc   = 0;
    endtask

    // Reference model: one step per rising edge
    always @(posedge clk) begin
        rec_t r;
        bit   psh;
        bit   wrong;
        if (rst_n) begin
            m_bms = 0;
            m_fl  = 0;
            if (m_left > 0) begin
                m_left--;
            end else begin
                psh = pred_valid && (mq.size() < DEPTH);
                if (res_valid) begin
                    if (mq.size() == 0) begin
                        m_err = 1;
                    end else begin
                        r = mq.pop_front();
                        wrong = (r.t != res_taken)
                             || (res_taken && r.tgt != res_target);
                        m_bms = 1;
                        m_abd = res_taken;
                        m_uba = r.pc;
                        m_mis = wrong;
                        if (m_bc < MAXC) m_bc++;
                        if (wrong) begin
                            if (m_mc < MAXC) m_mc++;
                            m_fl   = 1;
                            m_rpc  = res_taken ? res_target : r.pc + 32'd4;
                            mq.delete();
                            psh    = 0;
                            m_left = FLUSH;
                        end
                    end
                end
                if (psh) mq.push_back('{pred_taken, pred_pc, pred_target});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_reset();
            chk("rst_bms", branch_mem_sig, 0);
            chk("rst_abd", actual_branch_decision, 0);
            chk("rst_uba", update_branch_addr, 0);
            chk("rst_mis", mispredict, 0);
            chk("rst_flush", flush, 0);
            chk("rst_rpc", redirect_pc, 0);
            chk("rst_err", err_underflow, 0);
            chk("rst_bc", branch_count, 0);
            chk("rst_mc", mispredict_count, 0);
        end else begin
            chk("pred_ready", pred_ready,
                (m_left == 0 && mq.size() < DEPTH) ? 1 : 0);
            chk("branch_mem_sig", branch_mem_sig, m_bms);
            chk("actual_dec", actual_branch_decision, m_abd);
            chk("update_addr", update_branch_addr, m_uba);
            chk("mispredict", mispredict, m_mis);
            chk("flush", flush, m_fl);
            if (m_fl) chk("redirect_pc", redirect_pc, m_rpc);
            chk("err_underflow", err_underflow, m_err);
            chk("branch_count", branch_count, m_bc);
            chk("mispredict_count", mispredict_count, m_mc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic drive_pred(input logic t, input logic [31:0] pc,
                              input logic [31:0] tgt);
        pred_valid  = 1'b1;
        pred_taken  = t;
        pred_pc     = pc;
        pred_target = tgt;
    endtask

    task automatic drive_res(input logic t, input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_taken  = t;
        res_target = tgt;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 idle();
        #1 rst_n = 1'b0;
        #1;
        chk("async_bms", branch_mem_sig, 0);
        chk("async_uba", update_branch_addr, 0);
        chk("async_abd", actual_branch_decision, 0);
        chk("async_rpc", redirect_pc, 0);
        chk("async_err", err_underflow, 0);
        chk("async_bc", branch_count, 0);
        chk("async_mc", mispredict_count, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc();
        chk("ready_after_reset", pred_ready, 1);

        // Correct taken prediction
        drive_pred(1, 32'h100, 32'h140); cyc(); idle();
        drive_res(1, 32'h140); cyc(); idle();
        chk("t1_bms", branch_mem_sig, 1);
        chk("t1_uba", update_branch_addr, 32'h100);
        chk("t1_mis", mispredict, 0);
        chk("t1_flush", flush, 0);
        chk("t1_bc", branch_count, 1);
        chk("t1_model_bc", m_bc, 1);

        // Predicted not taken, actually taken
        drive_pred(0, 32'h200, 32'h204); cyc(); idle();
        drive_res(1, 32'h260); cyc(); idle();
        chk("t2_flush", flush, 1);
        chk("t2_rpc", redirect_pc, 32'h260);
        chk("t2_model_rpc", m_rpc, 32'h260);
        chk("t2_mc", mispredict_count, 1);
        chk("t2_ready0", pred_ready, 0);
        drive_res(1, 32'h999); cyc(); idle();
        chk("t2_ready1", pred_ready, 0);
        chk("t2_ignored_err", err_underflow, 0);
        chk("t2_ignored_bc", branch_count, 2);
        chk("t2_ignored_bms", branch_mem_sig, 0);
        cyc();
        chk("t2_ready_back", pred_ready, 1);

        // Predicted taken, actually not taken, with a same-cycle push
        drive_pred(1, 32'h300, 32'h380); cyc(); idle();
        drive_res(0, 32'h0);
        drive_pred(1, 32'h400, 32'h480); cyc(); idle();
        chk("t3_rpc", redirect_pc, 32'h304);
        chk("t3_flush", flush, 1);
        chk("t3_mc", mispredict_count, 2);
        cyc(); cyc();
        chk("t3_ready", pred_ready, 1);

        // Empty FIFO resolution: proves the dropped push and sets the flag
        drive_res(1, 32'h480); cyc(); idle();
        chk("t5_err", err_underflow, 1);
        chk("t5_bms", branch_mem_sig, 0);
        chk("t5_bc", branch_count, 3);
        cyc();
        chk("t5_err_sticky", err_underflow, 1);

        // Fill, then pop+push in one cycle
        for (int i = 0; i < DEPTH; i++) begin
            drive_pred(1, 32'h500 + 32'(16 * i), 32'h600 + 32'(16 * i));
            cyc(); idle();
        end
        chk("t4_full", pred_ready, 0);
        drive_res(1, 32'h600);
        drive_pred(1, 32'h540, 32'h640); cyc(); idle();
        chk("t4_uba0", update_branch_addr, 32'h500);
        chk("t4_mis0", mispredict, 0);
        chk("t4_ready", pred_ready, 1);
        drive_pred(1, 32'h540, 32'h640); cyc(); idle();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_res(1, 32'h600 + 32'(16 * i)); cyc(); idle();
            chk("t4_order", update_branch_addr, 32'h500 + 32'(16 * i));
            chk("t4_mis", mispredict, 0);
        end
        chk("t4_bc", branch_count, 8);

        // Reset drops in-flight records
        drive_pred(0, 32'h700, 32'h704); cyc(); idle();
        do_reset();
        drive_res(0, 32'h0); cyc(); idle();
        chk("rst_drop_err", err_underflow, 1);
        chk("rst_drop_bms", branch_mem_sig, 0);
        chk("rst_drop_bc", branch_count, 0);

        // Counter saturation
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive_pred(0, 32'h800 + 32'(4 * k), 32'h900); cyc(); idle();
            drive_res(1, 32'hA00 + 32'(k)); cyc(); idle();
            cyc(); cyc();
        end
        chk("t6_bc", branch_count, 15);
        chk("t6_mc", mispredict_count, 15);
        chk("t6_model_mc", m_mc, 15);

        // Asynchronous reset with live outputs
        drive_pred(1, 32'hB00, 32'hB40); cyc(); idle();
        drive_res(1, 32'hB40);
        do_reset();
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
